srl_fifo_ctrl: RTL



---
 rtl/srl_fifo_ctrl_pkg.sv | 8 +
 rtl/srl_fifo_ctrl_srlvec.sv | 31 +++
 rtl/srl_fifo_ctrl.sv | 74 +++++++
 3 files changed

// File: rtl/srl_fifo_ctrl_pkg.sv
// Shared sizing rule for the SRL FIFO controller and its vector shift register.
package srl_fifo_ctrl_pkg;

  function automatic int unsigned srl_addr_bits(input bit srl16);
    return srl16 ? 32'd4 : 32'd5;
  endfunction

endpackage

// File: rtl/srl_fifo_ctrl_srlvec.sv
// Vector shift register: one SRL16E/SRLC32E per data bit, shared CE and read address.
module srlvec
  import srl_fifo_ctrl_pkg::*;
#(
  parameter int unsigned NBITS     = 8,
  parameter string       USE_SRL16 = "TRUE",
  localparam int unsigned ADDR_BITS = srl_addr_bits(USE_SRL16 == "TRUE"),
  localparam int unsigned DEPTH     = 2 ** ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 ce,
  input  logic [ADDR_BITS-1:0] a,
  input  logic [NBITS-1:0]     din,
  output logic [NBITS-1:0]     dout
);

  // No reset on storage so the array maps onto SRL primitives.
  logic [NBITS-1:0] sr [DEPTH];

  always_ff @(posedge clk) begin
    if (ce) begin
      sr[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign dout = sr[a];

endmodule

// File: rtl/srl_fifo_ctrl.sv
// SRL-based synchronous FIFO controller with registered output stage and stream handshakes.
module srl_fifo_ctrl
  import srl_fifo_ctrl_pkg::*;
#(
  parameter int unsigned NBITS     = 8,
  parameter string       USE_SRL16 = "TRUE",
  localparam int unsigned ADDR_BITS = srl_addr_bits(USE_SRL16 == "TRUE"),
  localparam int unsigned DEPTH     = 2 ** ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [NBITS-1:0]     s_tdata,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  output logic [NBITS-1:0]     m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [ADDR_BITS:0]   count
);

  localparam int unsigned CW = ADDR_BITS + 1;

  logic [CW-1:0]        srl_cnt;
  logic [CW-1:0]        srl_cnt_next;
  logic [ADDR_BITS-1:0] srl_addr;
  logic [NBITS-1:0]     srl_dout;
  logic                 wr;
  logic                 ld;

  assign wr = s_tvalid & s_tready;
  assign ld = (srl_cnt != '0) & (~m_tvalid | m_tready);

  // Oldest entry sits at srl_cnt-1; the wrapped value at srl_cnt=0 is never loaded.
  assign srl_addr     = ADDR_BITS'(srl_cnt - CW'(1));
  assign srl_cnt_next = srl_cnt + CW'(wr) - CW'(ld);

  srlvec #(
    .NBITS     (NBITS),
    .USE_SRL16 (USE_SRL16)
  ) u_srlvec (
    .clk  (clk),
    .ce   (wr),
    .a    (srl_addr),
    .din  (s_tdata),
    .dout (srl_dout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      srl_cnt  <= '0;
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      s_tready <= 1'b1;
    end else if (flush) begin
      srl_cnt  <= '0;
      m_tvalid <= 1'b0;
      s_tready <= 1'b1;
    end else begin
      srl_cnt  <= srl_cnt_next;
      s_tready <= (srl_cnt_next != CW'(DEPTH));
      if (ld) begin
        m_tdata  <= srl_dout;
        m_tvalid <= 1'b1;
      end else if (m_tvalid & m_tready) begin
        // Not loading with m_tready high implies the SRL is empty.
        m_tvalid <= 1'b0;
      end
    end
  end

  assign count = srl_cnt + CW'(m_tvalid);

endmodule
